// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - memory-mapped GPIO bank: per-port data/dir, set/clr/toggle, synced inputs, edge IRQs
module gpio_bank #(
  parameter int NUM_PORTS   = 2,
  parameter int PORT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BOTH_EDGES  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cs,
  input  logic [7:0]                       addr,
  input  logic [3:0]                       wmask,
  input  logic [31:0]                      wdata,
  input  logic                             rstrb,
  output logic [31:0]                      rdata,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_oe,
  output logic                             irq
);

  localparam int         W       = NUM_PORTS * PORT_WIDTH;
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [2:0]            port_idx, reg_sel, arm_cnt;
  logic                  wr, rd, armed, irq_any, unused_bits;
  logic [31:0]           lane_mask, wval32;
  logic [PORT_WIDTH-1:0] wmask_p, wval, rd_val;
  logic [W-1:0]          sync_q [SYNC_STAGES];
  logic [W-1:0]          hist_q, din, edge_w;
  logic [PORT_WIDTH-1:0] dout_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_q  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] en_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] stat_q [NUM_PORTS];

  assign port_idx    = addr[7:5];
  assign reg_sel     = addr[4:2];
  assign wr          = cs & (|wmask);
  assign rd          = cs & rstrb;
  assign lane_mask   = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign wval32      = wdata & lane_mask;
  assign wmask_p     = lane_mask[PORT_WIDTH-1:0];
  assign wval        = wval32[PORT_WIDTH-1:0];
  assign unused_bits = ^{addr[1:0], wval32, lane_mask};

  // Edges are ignored until the synchroniser and history flops hold real pin values.
  assign din    = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_cnt == ARM_MAX);
  assign edge_w = armed ? ((din & ~hist_q) | ((BOTH_EDGES != 0) ? (~din & hist_q) : '0)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= din;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        dout_q[p] <= '0;
        dir_q[p]  <= '0;
        en_q[p]   <= '0;
        stat_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr && port_idx == 3'(p)) begin
          case (reg_sel)
            3'd0:    dout_q[p] <= (dout_q[p] & ~wmask_p) | wval;
            3'd1:    dir_q[p]  <= (dir_q[p] & ~wmask_p) | wval;
            3'd2:    dout_q[p] <= dout_q[p] | wval;
            3'd3:    dout_q[p] <= dout_q[p] & ~wval;
            3'd4:    dout_q[p] <= dout_q[p] ^ wval;
            3'd6:    en_q[p]   <= (en_q[p] & ~wmask_p) | wval;
            default: ;
          endcase
        end
        // A new edge overrides a same-cycle write-1-clear of that bit.
        stat_q[p] <= (stat_q[p] & ~((wr && port_idx == 3'(p) && reg_sel == 3'd7) ? wval : '0))
                   | (edge_w[p*PORT_WIDTH +: PORT_WIDTH] & en_q[p]);
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    irq_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irq_any = irq_any | (|(stat_q[p] & en_q[p]));
      if (port_idx == 3'(p)) begin
        case (reg_sel)
          3'd1:    rd_val = dir_q[p];
          3'd5:    rd_val = din[p*PORT_WIDTH +: PORT_WIDTH];
          3'd6:    rd_val = en_q[p];
          3'd7:    rd_val = stat_q[p];
          default: rd_val = dout_q[p];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (rd) rdata <= 32'(rd_val);
      irq <= irq_any;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pins
    assign gpio_out[g*PORT_WIDTH +: PORT_WIDTH] = dout_q[g];
    assign gpio_oe[g*PORT_WIDTH +: PORT_WIDTH]  = dir_q[g];
  end

endmodule
